// File: rtl/hidden_cpu_gen2.sv
// hidden_cpu_gen2 - parametrised 2-operand register core with carry, BCF, RAM and output select.
// Optional HCPU_RAM_CLEAR_EN: post-reset CLR sweep zeroes the RAM before the first instruction.
module hidden_cpu_gen2 #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int RAM_AW = 4,
  parameter int PC_W   = 8,
  localparam int RW    = $clog2(NREGS),
  localparam int IW    = 2 + 2 * RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] dout,
  output logic              carry,
  output logic              out_sel,
  output logic [PC_W-1:0]   pc
);

`ifdef HCPU_RAM_CLEAR_EN
  typedef enum logic [1:0] {S_RUN, S_MEM, S_CLR} state_t;
`else
  typedef enum logic {S_RUN, S_MEM} state_t;
`endif

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;

  localparam logic [1:0] SYS_LOAD  = 2'd0;
  localparam logic [1:0] SYS_STORE = 2'd1;
  localparam logic [1:0] SYS_BCF   = 2'd2;
  localparam logic [1:0] SYS_TOG   = 2'd3;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [PC_W-1:0]   r_pc;
  logic              r_carry;
  logic              r_out_sel;
  logic [RW-1:0]     r_load_rd;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_ram [2**RAM_AW];
`ifdef HCPU_RAM_CLEAR_EN
  logic [RAM_AW-1:0] r_clr_addr;
`endif

  logic [1:0]        w_op;
  logic [RW-1:0]     w_rd;
  logic [RW-1:0]     w_rs;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [RAM_AW-1:0] w_addr;
  logic              w_accept;
  logic              w_load_acc;
  logic              w_store_acc;
  logic              w_ram_we;
  logic [RAM_AW-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;

  assign w_op   = instr[IW-1 -: 2];
  assign w_rd   = instr[2*RW-1 -: RW];
  assign w_rs   = instr[RW-1:0];
  assign w_a    = r_regs[w_rd];
  assign w_b    = r_regs[w_rs];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  // The extra top bit of the difference is the unsigned borrow (w_a < w_b).
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_addr = RAM_AW'({r_regs[1], r_regs[2]});

  assign instr_ready = rst & (r_state == S_RUN);
  assign w_accept    = instr_valid & instr_ready;
  assign w_load_acc  = w_accept & (w_op == OP_SYS) & (w_rs[1:0] == SYS_LOAD);
  assign w_store_acc = w_accept & (w_op == OP_SYS) & (w_rs[1:0] == SYS_STORE);

`ifdef HCPU_RAM_CLEAR_EN
  assign w_ram_we    = w_store_acc | (r_state == S_CLR);
  assign w_ram_waddr = (r_state == S_CLR) ? r_clr_addr : w_addr;
  assign w_ram_wdata = (r_state == S_CLR) ? '0 : w_a;
`else
  assign w_ram_we    = w_store_acc;
  assign w_ram_waddr = w_addr;
  assign w_ram_wdata = w_a;
`endif

  assign dout    = r_out_sel ? DATA_W'(r_pc) : r_regs[NREGS-1];
  assign carry   = r_carry;
  assign out_sel = r_out_sel;
  assign pc      = r_pc;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_waddr] <= w_ram_wdata;
    end
    if (w_load_acc) begin
      r_rdata <= r_ram[w_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
      r_pc      <= '0;
      r_carry   <= 1'b0;
      r_out_sel <= 1'b0;
      r_load_rd <= '0;
`ifdef HCPU_RAM_CLEAR_EN
      r_clr_addr <= '0;
      r_state    <= S_CLR;
`else
      r_state    <= S_RUN;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          if (instr_valid) begin
            r_pc <= r_pc + 1'b1;
            case (w_op)
              OP_ADD: begin
                r_regs[w_rd] <= w_sum[DATA_W-1:0];
                r_carry      <= w_sum[DATA_W];
              end
              OP_SUB: begin
                r_regs[w_rd] <= w_diff[DATA_W-1:0];
                r_carry      <= w_diff[DATA_W];
              end
              OP_NAND: r_regs[w_rd] <= ~(w_a & w_b);
              default: begin
                case (w_rs[1:0])
                  SYS_LOAD: begin
                    r_load_rd <= w_rd;
                    r_state   <= S_MEM;
                  end
                  SYS_BCF: begin
                    if (r_carry) begin
                      r_pc <= r_pc + PC_W'(w_a);
                    end
                  end
                  SYS_TOG: r_out_sel <= ~r_out_sel;
                  default: ;
                endcase
              end
            endcase
          end
        end
        S_MEM: begin
          r_regs[r_load_rd] <= r_rdata;
          r_state           <= S_RUN;
        end
`ifdef HCPU_RAM_CLEAR_EN
        S_CLR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == {RAM_AW{1'b1}}) begin
            r_state <= S_RUN;
          end
        end
`endif
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_cpu_gen2.sv
// tb/tb_hidden_cpu_gen2.sv - directed self-checking bench for hidden_cpu_gen2.
module tb_hidden_cpu_gen2;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;
  localparam logic [1:0] SYS_LOAD  = 2'd0;
  localparam logic [1:0] SYS_STORE = 2'd1;
  localparam logic [1:0] SYS_BCF   = 2'd2;
  localparam logic [1:0] SYS_TOG   = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] dout;
  logic       carry;
  logic       out_sel;
  logic [7:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  hidden_cpu_gen2 dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .dout        (dout),
    .carry       (carry),
    .out_sel     (out_sel),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", instr_ready, 0);
    rst = 1'b1;
    #1;
  endtask

  task automatic exec(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs);
    int n;
    n = 0;
    @(negedge clk);
    instr = {op, rd, rs};
    instr_valid = 1'b1;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] val;

    // Reset state
    do_reset();
`ifdef HCPU_RAM_CLEAR_EN
    begin
      int lows;
      lows = 0;
      while (!instr_ready && lows < 40) begin
        @(posedge clk);
        #1;
        lows++;
      end
      check("clr_sweep_cycles", lows, 16);
    end
`else
    check("rst_ready_first_cycle", instr_ready, 1);
`endif
    check("rst_dout", dout, 8'h03);
    check("rst_pc", pc, 0);
    check("rst_carry", carry, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_r0", dut.r_regs[0], 0);
    check("rst_r1", dut.r_regs[1], 1);

`ifdef HCPU_RAM_CLEAR_EN
    exec(OP_SYS, 2'd3, SYS_LOAD);
    @(posedge clk);
    #1;
    check("clr_load_zero", dout, 0);
    do_reset();
`endif

    // SUB borrow, NAND keeps carry
    exec(OP_SUB, 2'd0, 2'd1);
    check("sub_0m1_r0", dut.r_regs[0], 8'hFF);
    check("sub_0m1_carry", carry, 1);
    exec(OP_SUB, 2'd3, 2'd2);
    check("sub_3m2_dout", dout, 8'h01);
    check("sub_3m2_carry", carry, 0);
    exec(OP_NAND, 2'd2, 2'd2);
    check("nand_r2", dut.r_regs[2], 8'hFD);
    exec(OP_NAND, 2'd3, 2'd1);
    check("nand_dout", dout, 8'hFE);
    check("nand_carry", carry, 0);
    check("alu_pc", pc, 4);

    // ADD overflow with rd==rs
    do_reset();
    for (int i = 0; i < 7; i++) exec(OP_ADD, 2'd1, 2'd1);
    exec(OP_SUB, 2'd3, 2'd3);
    check("sub_self_carry", carry, 0);
    exec(OP_ADD, 2'd3, 2'd1);
    check("add_r3_80", dout, 8'h80);
    exec(OP_ADD, 2'd3, 2'd3);
    check("add_ovf_dout", dout, 8'h00);
    check("add_ovf_carry", carry, 1);
    check("add_ovf_pc", pc, 10);

    // STORE / LOAD with valid held during MEM
    do_reset();
    exec(OP_ADD, 2'd2, 2'd3);
    exec(OP_SUB, 2'd3, 2'd3);
    val = 8'hA5;
    for (int b = 7; b >= 0; b--) begin
      exec(OP_ADD, 2'd3, 2'd3);
      if (val[b]) exec(OP_ADD, 2'd3, 2'd1);
    end
    exec(OP_SUB, 2'd1, 2'd1);
    check("build_a5", dout, 8'hA5);
    check("build_pc", pc, 15);
    exec(OP_SYS, 2'd3, SYS_STORE);
    @(negedge clk);
    instr = {OP_SYS, 2'd0, SYS_LOAD};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ld_ready_low", instr_ready, 0);
    check("ld_pc_at_accept", pc, 17);
    instr = {OP_SYS, 2'd0, SYS_TOG};
    @(posedge clk);
    #1;
    check("ld_r0", dut.r_regs[0], 8'hA5);
    check("ld_ready_back", instr_ready, 1);
    check("hold_no_exec", out_sel, 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("tog_once", out_sel, 1);
    check("tog_dout_pc", dout, 8'h12);
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_pc", pc, 8'h12);
    exec(OP_SYS, 2'd0, SYS_TOG);
    check("tog_back_dout", dout, 8'hA5);

    // BCF taken / not taken / wrap
    do_reset();
    exec(OP_SUB, 2'd0, 2'd1);
    for (int i = 0; i < 9; i++) exec(OP_NAND, 2'd0, 2'd0);
    check("bcf_pre_pc", pc, 10);
    check("bcf_pre_carry", carry, 1);
    exec(OP_SYS, 2'd2, SYS_BCF);
    check("bcf_taken_pc", pc, 12);
    exec(OP_SUB, 2'd3, 2'd3);
    exec(OP_SYS, 2'd2, SYS_BCF);
    check("bcf_not_taken_pc", pc, 14);
    for (int i = 0; i < 241; i++) exec(OP_NAND, 2'd0, 2'd0);
    check("pc_255", pc, 255);
    exec(OP_SYS, 2'd2, SYS_BCF);
    check("pc_wrap", pc, 0);

    // Reset during MEM aborts the load
    do_reset();
    exec(OP_SYS, 2'd0, SYS_STORE);
    @(negedge clk);
    instr = {OP_SYS, 2'd3, SYS_LOAD};
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("abort_ready_low", instr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_in_rst", instr_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rd_kept", dout, 8'h03);
    check("abort_pc", pc, 0);
`ifndef HCPU_RAM_CLEAR_EN
    check("abort_ready", instr_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
